ascon_perm_sequencer: RTL and testbench
=======================================

Name: ascon_perm_sequencer

Overview:
- Control FSM for the ASCON-128 encryption datapath: permutation round logic plus the 320-bit state register.
- Sequences the phases in order: initialisation (pa), one associated-data block (pb), NB_PT_BLOCKS plaintext blocks (pb for all but the last), finalisation (pa).
- Per cycle it drives the state-register enable, input mux select, XOR-begin/XOR-end enables, round constant index, cipher/tag capture strobes and status.
- Instantiated beside the datapath at the ascon_top level.

Parameters:
- NB_PT_BLOCKS, 4, number of 64-bit plaintext blocks per message (legal range 1..15)
- ROUNDS_A, 12, rounds of pa (initialisation/finalisation)
- ROUNDS_B, 6, rounds of pb (AD/plaintext)

Ports:
- clock_i  in  1  clock
- resetb_i  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a new message; sampled only in IDLE
- data_valid_i  in  1  next 64-bit AD/plaintext block is present on the datapath input; sampled only in WAIT_AD/WAIT_PT
- init_o  out  1  state mux selects the IV‖K‖N initial value
- en_reg_state_o  out  1  state register load enable
- en_xor_data_begin_o  out  1  XOR input block into x0 before the round
- en_xor_key_begin_o  out  1  XOR key into x1,x2 before the round
- en_xor_key_end_o  out  1  XOR key into x3,x4 after the round
- en_xor_lsb_end_o  out  1  XOR domain-separation bit into x4 LSB after the round
- round_o  out  4  round constant index 0..11
- en_cipher_o  out  1  capture ciphertext block (x0 after data XOR)
- en_tag_o  out  1  capture tag
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse, message complete

Behaviour:
- Reset: state IDLE, round counter 0, block counter 0. All outputs 0 while resetb_i is low.
- Reset asserted mid-operation aborts immediately to IDLE. No residual pulses after release.
- Outputs are Moore-decoded from state, round counter and block counter only. No combinational path from any input to any output.
- One permutation round per cycle in every ROUND state. en_reg_state_o=1 in every ROUND state and 0 elsewhere.
- pa uses round_o 0..11. pb uses round_o 6..11. Counter start value is 12-ROUNDS_x.
- IDLE: if start_i, go to INIT and load round 0.
- INIT (pa):
  - round 0: init_o=1
  - round 11: en_xor_key_end_o=1
  - after round 11: go to WAIT_AD
- WAIT_AD: all enables 0. If data_valid_i, go to AD and load round 6.
- AD (pb):
  - round 6: en_xor_data_begin_o=1
  - round 11: en_xor_lsb_end_o=1
  - after round 11: go to WAIT_PT
- WAIT_PT: if data_valid_i:
  - block counter < NB_PT_BLOCKS-1: go to PT, round 6
  - otherwise: go to FINAL, round 0
- PT (pb):
  - round 6: en_xor_data_begin_o=1, en_cipher_o=1
  - after round 11: block counter +1, go to WAIT_PT
- FINAL (pa):
  - round 0: en_xor_data_begin_o=1, en_cipher_o=1, en_xor_key_begin_o=1
  - round 11: en_xor_key_end_o=1, en_tag_o=1
  - after round 11: go to DONE
- DONE: done_o=1 for exactly one cycle, then go to IDLE. Block counter clears to 0.
- Ignored inputs:
  - start_i while busy_o=1
  - data_valid_i outside WAIT_AD/WAIT_PT
  - data_valid_i held high simply keeps the sequence back-to-back; 0 wait cycles is legal.
- Latency with data_valid_i always high, NB_PT_BLOCKS=4: 1 (IDLE→INIT) + 12 + 4×(1 wait + 6) + 12 + 1 = 54 cycles from the start_i cycle to done_o.

Optional Feature:
- Macro ASCON_ABORT_EN adds input abort_i (1 bit).
- Defined: abort_i=1 in any non-IDLE state forces IDLE on the next edge with counters cleared. No done_o and no en_tag_o in that cycle; outputs are 0 in the cycle after. abort_i has priority over every transition.
- Undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- ascon_pack additions:
  - enum type_seq_state {IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE}
  - constants ROUND_LAST=4'd11, ROUND_A_START=4'd0, ROUND_B_START=4'd6
- Sub-module round_counter: 4-bit counter with synchronous load of a start value, increment enable, and last_o flag at 11. Same reset style.
- Block counter stays inline.

Test Plan:
- Reset release, then start_i pulse with data_valid_i tied 1 → init_o=1 with round_o=0 one cycle after start; round_o steps 0..11; en_xor_key_end_o high at round 11; done_o at cycle 54.
- data_valid_i held 0 for 5 cycles in WAIT_AD and WAIT_PT → en_reg_state_o=0 and round_o stable during the waits; total latency grows by exactly 10.
- Count strobes over one message → en_cipher_o fires exactly 4 times (3×PT round 6, 1×FINAL round 0); en_xor_lsb_end_o once; en_tag_o once, coincident with round_o=11 of FINAL.
- start_i pulsed during PT, and data_valid_i pulsed during INIT → no state, counter or output change versus a reference run.
- resetb_i low for 1 cycle at FINAL round 5 → all outputs 0 immediately; start_i afterwards produces a full normal 54-cycle sequence.
- With ASCON_ABORT_EN: abort_i at AD round 8 → next cycle busy_o=0, en_reg_state_o=0, no done_o; a following start_i runs normally.

Source files
------------

// File: rtl/ascon_perm_sequencer_pkg.sv
// Shared types and constants for the ASCON-128 permutation sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package ascon_perm_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_AD,
        AD,
        WAIT_PT,
        PT,
        FINAL,
        DONE
    } type_seq_state;

    localparam logic [3:0] ROUND_LAST    = 4'd11;
    localparam logic [3:0] ROUND_A_START = 4'd0;
    localparam logic [3:0] ROUND_B_START = 4'd6;

    // A permutation of N rounds always finishes on constant index 11.
    function automatic logic [3:0] round_start(input int rounds);
        return 4'(12 - rounds);
    endfunction

endpackage

// File: rtl/ascon_perm_sequencer_if.sv
// Control bundle between the sequencer and its host (start/data handshake, datapath strobes).
// Latency: n/a (wiring only).
// Backpressure: data_valid_i stalls the sequencer in its wait states; ASCON_ABORT_EN adds abort_i.
interface ascon_perm_sequencer_if;
`ifdef ASCON_ABORT_EN
    logic       abort_i;
`endif
    logic       start_i;
    logic       data_valid_i;
    logic       init_o;
    logic       en_reg_state_o;
    logic       en_xor_data_begin_o;
    logic       en_xor_key_begin_o;
    logic       en_xor_key_end_o;
    logic       en_xor_lsb_end_o;
    logic [3:0] round_o;
    logic       en_cipher_o;
    logic       en_tag_o;
    logic       busy_o;
    logic       done_o;

    modport master (
`ifdef ASCON_ABORT_EN
        output abort_i,
`endif
        output start_i, data_valid_i,
        input  init_o, en_reg_state_o, en_xor_data_begin_o, en_xor_key_begin_o,
        input  en_xor_key_end_o, en_xor_lsb_end_o, round_o, en_cipher_o,
        input  en_tag_o, busy_o, done_o
    );

    modport slave (
`ifdef ASCON_ABORT_EN
        input  abort_i,
`endif
        input  start_i, data_valid_i,
        output init_o, en_reg_state_o, en_xor_data_begin_o, en_xor_key_begin_o,
        output en_xor_key_end_o, en_xor_lsb_end_o, round_o, en_cipher_o,
        output en_tag_o, busy_o, done_o
    );
endinterface

// File: rtl/ascon_perm_sequencer_round_counter.sv
// 4-bit round-constant counter: synchronous load of a start index, increment, last flag at 11.
// Latency: load/increment visible one cycle later; last_o is decoded from the register.
// Backpressure: none; holds its value when neither load_i nor inc_i is set.
module ascon_perm_sequencer_round_counter
    import ascon_perm_sequencer_pkg::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       inc_i,
    output logic [3:0] cnt_o,
    output logic       last_o
);
    logic [3:0] cnt_d, cnt_q;

    // Load wins over increment so a phase change can restart the count in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Round counter register.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == ROUND_LAST);
endmodule

// File: rtl/ascon_perm_sequencer.sv
// ASCON-128 encryption phase sequencer: pa init, pb AD, pb plaintext blocks, pa final. Optional ASCON_ABORT_EN adds abort_i.
// Latency: one round per cycle; 54 cycles start->done_o with data_valid_i high and 4 blocks.
// Backpressure: waits in WAIT_AD/WAIT_PT until data_valid_i; start_i ignored while busy.
module ascon_perm_sequencer
    import ascon_perm_sequencer_pkg::*;
#(
    parameter int NB_PT_BLOCKS = 4,
    parameter int ROUNDS_A     = 12,
    parameter int ROUNDS_B     = 6
) (
    input  logic                   clock_i,
    input  logic                   resetb_i,
    ascon_perm_sequencer_if.slave  bus
);
    localparam logic [3:0] RA_START = round_start(ROUNDS_A);
    localparam logic [3:0] RB_START = round_start(ROUNDS_B);
    localparam logic [3:0] BLK_LAST = 4'(NB_PT_BLOCKS - 1);

    type_seq_state state_d, state_q;
    logic [3:0]    blk_d, blk_q;
    logic          rc_load, rc_inc, rc_last;
    logic [3:0]    rc_load_val, rnd;

    ascon_perm_sequencer_round_counter u_round_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load_i     (rc_load),
        .load_val_i (rc_load_val),
        .inc_i      (rc_inc),
        .cnt_o      (rnd),
        .last_o     (rc_last)
    );

    // Phase transitions and round/block counter control.
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        rc_load     = 1'b0;
        rc_load_val = ROUND_A_START;
        rc_inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d     = INIT;
                    rc_load     = 1'b1;
                    rc_load_val = RA_START;
                end
            end
            INIT: begin
                if (rc_last) state_d = WAIT_AD;
                else         rc_inc  = 1'b1;
            end
            WAIT_AD: begin
                if (bus.data_valid_i) begin
                    state_d     = AD;
                    rc_load     = 1'b1;
                    rc_load_val = RB_START;
                end
            end
            AD: begin
                if (rc_last) state_d = WAIT_PT;
                else         rc_inc  = 1'b1;
            end
            WAIT_PT: begin
                // The last plaintext block is absorbed by the finalisation permutation.
                if (bus.data_valid_i) begin
                    rc_load = 1'b1;
                    if (blk_q < BLK_LAST) begin
                        state_d     = PT;
                        rc_load_val = RB_START;
                    end else begin
                        state_d     = FINAL;
                        rc_load_val = RA_START;
                    end
                end
            end
            PT: begin
                if (rc_last) begin
                    state_d = WAIT_PT;
                    blk_d   = blk_q + 4'd1;
                end else begin
                    rc_inc = 1'b1;
                end
            end
            FINAL: begin
                if (rc_last) state_d = DONE;
                else         rc_inc  = 1'b1;
            end
            DONE: begin
                state_d     = IDLE;
                blk_d       = 4'd0;
                rc_load     = 1'b1;
                rc_load_val = ROUND_A_START;
            end
            default: begin
                state_d = IDLE;
                blk_d   = 4'd0;
                rc_load = 1'b1;
            end
        endcase
`ifdef ASCON_ABORT_EN
        // Abort overrides any transition and leaves everything as after reset.
        if (bus.abort_i && (state_q != IDLE)) begin
            state_d     = IDLE;
            blk_d       = 4'd0;
            rc_load     = 1'b1;
            rc_load_val = ROUND_A_START;
            rc_inc      = 1'b0;
        end
`endif
    end

    // State and block counter registers.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            blk_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
        end
    end

    // Moore decode of the datapath strobes from state and round index only.
    always_comb begin
        bus.init_o              = 1'b0;
        bus.en_reg_state_o      = 1'b0;
        bus.en_xor_data_begin_o = 1'b0;
        bus.en_xor_key_begin_o  = 1'b0;
        bus.en_xor_key_end_o    = 1'b0;
        bus.en_xor_lsb_end_o    = 1'b0;
        bus.en_cipher_o         = 1'b0;
        bus.en_tag_o            = 1'b0;
        bus.busy_o              = (state_q != IDLE);
        bus.done_o              = (state_q == DONE);
        bus.round_o             = rnd;
        unique case (state_q)
            INIT: begin
                bus.en_reg_state_o   = 1'b1;
                bus.init_o           = (rnd == RA_START);
                bus.en_xor_key_end_o = rc_last;
            end
            AD: begin
                bus.en_reg_state_o      = 1'b1;
                bus.en_xor_data_begin_o = (rnd == RB_START);
                bus.en_xor_lsb_end_o    = rc_last;
            end
            PT: begin
                bus.en_reg_state_o      = 1'b1;
                bus.en_xor_data_begin_o = (rnd == RB_START);
                bus.en_cipher_o         = (rnd == RB_START);
            end
            FINAL: begin
                bus.en_reg_state_o      = 1'b1;
                bus.en_xor_data_begin_o = (rnd == RA_START);
                bus.en_cipher_o         = (rnd == RA_START);
                bus.en_xor_key_begin_o  = (rnd == RA_START);
                bus.en_xor_key_end_o    = rc_last;
                bus.en_tag_o            = rc_last;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Directed bench for ascon_perm_sequencer: vector table for the nominal message plus timeline-checked corner runs.
// Latency: n/a.
// Backpressure: drives data_valid_i low in wait states to exercise stalls.
module tb_ascon_perm_sequencer;
    logic clock_i  = 1'b0;
    logic resetb_i = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    ascon_perm_sequencer_if bus ();

    ascon_perm_sequencer #(
        .NB_PT_BLOCKS (4),
        .ROUNDS_A     (12),
        .ROUNDS_B     (6)
    ) dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .bus      (bus)
    );

    always #5 clock_i = ~clock_i;

    // Output vector: {init, en_reg, xor_data_b, xor_key_b, xor_key_e, xor_lsb_e, cipher, tag, busy, done, round[3:0]}
    function automatic logic [13:0] mk(input bit init, input bit rg, input bit xdb, input bit xkb,
                                       input bit xke, input bit xle, input bit cip, input bit tag,
                                       input bit busy, input bit done, input int rnd);
        return {init, rg, xdb, xkb, xke, xle, cip, tag, busy, done, 4'(rnd)};
    endfunction

    function automatic logic [13:0] cur_out();
        return {bus.init_o, bus.en_reg_state_o, bus.en_xor_data_begin_o, bus.en_xor_key_begin_o,
                bus.en_xor_key_end_o, bus.en_xor_lsb_end_o, bus.en_cipher_o, bus.en_tag_o,
                bus.busy_o, bus.done_o, bus.round_o};
    endfunction

    // Expected outputs at cycle t of a 4-block message started at t=0, with wad extra
    // wait cycles in WAIT_AD and wpt extra wait cycles in the first WAIT_PT.
    function automatic logic [13:0] exp_out(input int t, input int wad, input int wpt);
        int a, p0, f, d, r, u;
        a  = 14 + wad;
        p0 = a + 7 + wpt;
        f  = p0 + 21;
        d  = f + 12;
        if (t <= 0 || t > d) return mk(0,0,0,0,0,0,0,0,0,0,0);
        if (t <= 12) begin
            r = t - 1;
            return mk(r == 0,1,0,0,r == 11,0,0,0,1,0,r);
        end
        if (t < a) return mk(0,0,0,0,0,0,0,0,1,0,11);
        if (t < a + 6) begin
            r = 6 + t - a;
            return mk(0,1,r == 6,0,0,r == 11,0,0,1,0,r);
        end
        if (t < p0) return mk(0,0,0,0,0,0,0,0,1,0,11);
        if (t < f) begin
            u = (t - p0) % 7;
            if (u == 6) return mk(0,0,0,0,0,0,0,0,1,0,11);
            r = 6 + u;
            return mk(0,1,r == 6,0,0,0,r == 6,0,1,0,r);
        end
        if (t < d) begin
            r = t - f;
            return mk(0,1,r == 0,r == 0,r == 11,0,r == 0,r == 11,1,0,r);
        end
        return mk(0,0,0,0,0,0,0,0,1,1,11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // One message with per-cycle comparison against the timeline. rst_at / abort_at (>=0)
    // interrupt the message at that cycle instead of letting it complete.
    task automatic run_msg(input string nm, input int wad, input int wpt, input bit inj,
                           input int rst_at, input int abort_at);
        int a, p0, d, mism, done_cyc, n_cip, n_lsb, n_tag, n_tag11, n_ke;
        logic [13:0] o, e;
        a = 14 + wad; p0 = a + 7 + wpt; d = p0 + 33;
        mism = 0; done_cyc = -1; n_cip = 0; n_lsb = 0; n_tag = 0; n_tag11 = 0; n_ke = 0;
        for (int t = 0; t <= d + 2; t++) begin
            o = cur_out();
            e = exp_out(t, wad, wpt);
            if (o !== e) begin
                if (mism == 0)
                    $display("FAIL %s_trace cycle=%0d actual=0x%0h expected=0x%0h", nm, t, o, e);
                mism++;
            end
            if (bus.done_o && done_cyc < 0) done_cyc = t;
            n_cip  += int'(bus.en_cipher_o);
            n_lsb  += int'(bus.en_xor_lsb_end_o);
            n_tag  += int'(bus.en_tag_o);
            n_ke   += int'(bus.en_xor_key_end_o);
            if (bus.en_tag_o && bus.round_o == 4'd11) n_tag11++;
            if (t == rst_at) begin
                chk({nm, "_pre_reset"}, 32'(mism), 32'd0);
                resetb_i = 1'b0;
                #1;
                chk({nm, "_reset_async"}, 32'(cur_out()), 32'd0);
                step();
                chk({nm, "_reset_held"}, 32'(cur_out()), 32'd0);
                resetb_i = 1'b1;
                return;
            end
`ifdef ASCON_ABORT_EN
            if (t == abort_at) begin
                chk({nm, "_pre_abort"}, 32'(mism), 32'd0);
                bus.abort_i = 1'b1;
                step();
                bus.abort_i = 1'b0;
                chk({nm, "_abort_outputs"}, 32'(cur_out()), 32'd0);
                chk({nm, "_abort_busy"}, 32'(bus.busy_o), 32'd0);
                step();
                chk({nm, "_abort_no_done"}, 32'(cur_out()), 32'd0);
                return;
            end
`endif
            // Inputs for this cycle.
            bus.start_i      = (t == 0) || (inj && t == p0 + 2);
            bus.data_valid_i = !((t >= 13 && t < 13 + wad) || (t >= a + 6 && t < a + 6 + wpt));
            if (inj && t >= 1 && t <= 12) bus.data_valid_i = (t == 5);
            step();
        end
        bus.start_i = 1'b0;
        chk({nm, "_trace"}, 32'(mism), 32'd0);
        chk({nm, "_done_cycle"}, 32'(done_cyc), 32'(d));
        chk({nm, "_cipher_count"}, 32'(n_cip), 32'd4);
        chk({nm, "_lsb_count"}, 32'(n_lsb), 32'd1);
        chk({nm, "_tag_count"}, 32'(n_tag), 32'd1);
        chk({nm, "_tag_at_round11"}, 32'(n_tag11), 32'd1);
        chk({nm, "_key_end_count"}, 32'(n_ke), 32'd2);
    endtask

    typedef struct {
        int          cyc;
        logic        start;
        logic        dv;
        logic [13:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[16];
        int   cyc;

        tbl[0]  = '{0,  1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0)};
        tbl[1]  = '{1,  1'b0, 1'b1, mk(1,1,0,0,0,0,0,0,1,0,0)};
        tbl[2]  = '{2,  1'b0, 1'b1, mk(0,1,0,0,0,0,0,0,1,0,1)};
        tbl[3]  = '{12, 1'b0, 1'b1, mk(0,1,0,0,1,0,0,0,1,0,11)};
        tbl[4]  = '{13, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,1,0,11)};
        tbl[5]  = '{14, 1'b0, 1'b1, mk(0,1,1,0,0,0,0,0,1,0,6)};
        tbl[6]  = '{19, 1'b0, 1'b1, mk(0,1,0,0,0,1,0,0,1,0,11)};
        tbl[7]  = '{20, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,1,0,11)};
        tbl[8]  = '{21, 1'b0, 1'b1, mk(0,1,1,0,0,0,1,0,1,0,6)};
        tbl[9]  = '{26, 1'b0, 1'b1, mk(0,1,0,0,0,0,0,0,1,0,11)};
        tbl[10] = '{41, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,1,0,11)};
        tbl[11] = '{42, 1'b0, 1'b1, mk(0,1,1,1,0,0,1,0,1,0,0)};
        tbl[12] = '{47, 1'b0, 1'b1, mk(0,1,0,0,0,0,0,0,1,0,5)};
        tbl[13] = '{53, 1'b0, 1'b1, mk(0,1,0,0,1,0,0,1,1,0,11)};
        tbl[14] = '{54, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,1,1,11)};
        tbl[15] = '{55, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0)};

        // Inputs active during reset must not leak to the outputs.
        bus.start_i      = 1'b1;
        bus.data_valid_i = 1'b1;
`ifdef ASCON_ABORT_EN
        bus.abort_i      = 1'b0;
`endif
        #1;
        chk("reset_outputs", 32'(cur_out()), 32'd0);
        step();
        step();
        chk("reset_outputs_clocked", 32'(cur_out()), 32'd0);
        bus.start_i = 1'b0;
        @(negedge clock_i);
        resetb_i = 1'b1;
        step();

        // Nominal message, data_valid_i tied high.
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            while (cyc < tbl[i].cyc) begin
                step();
                cyc++;
                bus.start_i = 1'b0;
            end
            chk($sformatf("vec%0d_cyc%0d", i, tbl[i].cyc), 32'(cur_out()), 32'(tbl[i].exp));
            bus.start_i      = tbl[i].start;
            bus.data_valid_i = tbl[i].dv;
        end
        bus.start_i = 1'b0;
        step();

        run_msg("nominal",    0, 0, 1'b0, -1, -1);
        run_msg("stall5",     5, 5, 1'b0, -1, -1);
        run_msg("ignored_in", 0, 0, 1'b1, -1, -1);
        run_msg("reset_final_r5", 0, 0, 1'b0, 47, -1);
        run_msg("after_reset", 0, 0, 1'b0, -1, -1);
`ifdef ASCON_ABORT_EN
        run_msg("abort_ad_r8", 0, 0, 1'b0, -1, 16);
        run_msg("after_abort", 0, 0, 1'b0, -1, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
